// File: rtl/pulse_conditioner.sv
// Four-channel pulse input conditioner: 2-flop sync, glitch filter, rising-edge strobe, idle timeout.
// Optional per-channel rejected-glitch counters when PULSE_GLITCH_CNT_EN is defined.
module pulse_conditioner #(
   parameter int unsigned FILT_LEN = 4,
   parameter int unsigned TIMEOUT  = 40_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_in_0,
   input  logic pulse_in_1,
   input  logic pulse_in_2,
   input  logic pulse_in_3,
   output logic pulse_out_0,
   output logic pulse_out_1,
   output logic pulse_out_2,
   output logic pulse_out_3,
   output logic level_out_0,
   output logic level_out_1,
   output logic level_out_2,
   output logic level_out_3,
   output logic no_signal_0,
   output logic no_signal_1,
   output logic no_signal_2,
   output logic no_signal_3
`ifdef PULSE_GLITCH_CNT_EN
   ,
   output logic [15:0] glitch_cnt_0,
   output logic [15:0] glitch_cnt_1,
   output logic [15:0] glitch_cnt_2,
   output logic [15:0] glitch_cnt_3
`endif
);

   localparam int          NCH       = 4;
   localparam logic [7:0]  FILT_LAST = 8'(FILT_LEN - 1);
   localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

   logic [NCH-1:0] pin;
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] s;
   logic [NCH-1:0] lvl;
   logic [NCH-1:0] strobe;
   logic [NCH-1:0] no_sig;
   logic [NCH-1:0] rise;
   logic [7:0]     cnt  [NCH];
   logic [31:0]    idle [NCH];

   assign pin = {pulse_in_3, pulse_in_2, pulse_in_1, pulse_in_0};

   // rise: the filter accepts a new high level on this edge
   always_comb begin
      rise = '0;
      for (int i = 0; i < NCH; i++) begin
         rise[i] = !lvl[i] && s[i] && (cnt[i] == FILT_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         s      <= '0;
         lvl    <= '0;
         strobe <= '0;
         no_sig <= '1;
         for (int i = 0; i < NCH; i++) begin
            cnt[i]  <= '0;
            idle[i] <= '0;
         end
      end else begin
         sync1  <= pin;
         s      <= sync1;
         strobe <= rise;
         for (int i = 0; i < NCH; i++) begin
            if (s[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == FILT_LAST) begin
               lvl[i] <= s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end

            // A strobe always wins over timer saturation
            if (rise[i]) begin
               idle[i]   <= '0;
               no_sig[i] <= 1'b0;
            end else if (idle[i] == IDLE_LAST) begin
               no_sig[i] <= 1'b1;
            end else begin
               idle[i] <= idle[i] + 32'd1;
            end
         end
      end
   end

   assign pulse_out_0 = strobe[0];
   assign pulse_out_1 = strobe[1];
   assign pulse_out_2 = strobe[2];
   assign pulse_out_3 = strobe[3];
   assign level_out_0 = lvl[0];
   assign level_out_1 = lvl[1];
   assign level_out_2 = lvl[2];
   assign level_out_3 = lvl[3];
   assign no_signal_0 = no_sig[0];
   assign no_signal_1 = no_sig[1];
   assign no_signal_2 = no_sig[2];
   assign no_signal_3 = no_sig[3];

`ifdef PULSE_GLITCH_CNT_EN
   logic [15:0] gcnt [NCH];

   // An excursion is rejected when s returns to lvl while cnt is still running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            gcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (s[i] == lvl[i] && cnt[i] != 8'd0 && gcnt[i] != 16'hFFFF) begin
               gcnt[i] <= gcnt[i] + 16'd1;
            end
         end
      end
   end

   assign glitch_cnt_0 = gcnt[0];
   assign glitch_cnt_1 = gcnt[1];
   assign glitch_cnt_2 = gcnt[2];
   assign glitch_cnt_3 = gcnt[3];
`endif

endmodule
